// File: rtl/exec_stage_pkg.sv
// Bundle package for the execute stage: control struct, ALU/MDU function codes,
// operand selects, bubble encodings and the MDU state type.
package exec_stage_pkg;

  // Bit 4 set marks the multiply/divide group; bit 2 within it selects divide.
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SRL   = 5'd3,
    ALU_SRA   = 5'd4,  ALU_AND  = 5'd5,  ALU_OR   = 5'd6,  ALU_XOR   = 5'd7,
    ALU_SLT   = 5'd8,  ALU_SLTU = 5'd9,  ALU_COPY1 = 5'd10,
    ALU_MUL   = 5'd16, ALU_MULH = 5'd17, ALU_MULHU = 5'd18,
    ALU_DIV   = 5'd20, ALU_DIVU = 5'd21, ALU_REM  = 5'd22, ALU_REMU  = 5'd23
  } alu_fun_e;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_IMZ} op1_sel_e;
  typedef enum logic [2:0] {OP2_RS2, OP2_ITYPE, OP2_STYPE, OP2_SBTYPE, OP2_UTYPE, OP2_UJTYPE} op2_sel_e;

  localparam logic [3:0] BR_N   = 4'd0;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic       M_X    = 1'b0;
  localparam logic [2:0] MT_X   = 3'd0;
  localparam logic [2:0] CSR_N  = 3'd0;

  typedef struct packed {
    logic [3:0] br_type;
    op1_sel_e   op1_sel;
    op2_sel_e   op2_sel;
    alu_fun_e   alu_fun;
    logic [1:0] wb_sel;
    logic       rf_wen;
    logic       mem_val;
    logic       mem_fcn;
    logic [2:0] mem_typ;
    logic [2:0] csr_cmd;
  } exec_ctrl_t;

  localparam exec_ctrl_t CTRL_BUBBLE = '{
    br_type: BR_N, op1_sel: OP1_RS1, op2_sel: OP2_RS2, alu_fun: ALU_ADD, wb_sel: WB_ALU,
    rf_wen: 1'b0, mem_val: 1'b0, mem_fcn: M_X, mem_typ: MT_X, csr_cmd: CSR_N};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mdu_state_e;

  function automatic logic is_mdu(input alu_fun_e f);
    return f[4];
  endfunction

endpackage

// File: rtl/exec_stage_if.sv
// Decode -> execute handshake bundle; decode is the master, the execute stage the slave.
interface exec_stage_if
  import exec_stage_pkg::*;
#(parameter int XLEN = 32);
  logic            valid, ready, kill;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst;
  logic [4:0]      wb_addr, rs1_addr, rs2_addr;
  logic [XLEN-1:0] op1_data, op2_data, rs2_data;
  exec_ctrl_t      ctrl;

  modport master (output valid, kill, pc, inst, wb_addr, rs1_addr, rs2_addr,
                         op1_data, op2_data, rs2_data, ctrl,
                  input  ready);
  modport slave  (input  valid, kill, pc, inst, wb_addr, rs1_addr, rs2_addr,
                         op1_data, op2_data, rs2_data, ctrl,
                  output ready);
endinterface

// File: rtl/exec_muldiv.sv
// Iterative multiply/divide: one shift-add or restoring-divide bit per enabled cycle,
// XLEN iterations after start. Signed ops run on magnitudes and fix the sign at the end.
module exec_muldiv
  import exec_stage_pkg::*;
#(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic            en,
  input  alu_fun_e        fun,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN:0]     hi;
  logic [XLEN-1:0]   lo, dvs;
  logic [CW-1:0]     cnt;
  alu_fun_e          fun_q;
  logic              neg_lo, neg_hi;
  logic              sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, mul_nxt, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    sgn      = (fun == ALU_MULH) || (fun == ALU_DIV) || (fun == ALU_REM);
    a_neg    = sgn && a[XLEN-1];
    b_neg    = sgn && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    mul_sum  = {1'b0, hi[XLEN-1:0]} + {1'b0, dvs};
    mul_nxt  = lo[0] ? mul_sum : {1'b0, hi[XLEN-1:0]};
    div_sh   = {hi[XLEN-1:0], lo[XLEN-1]};
    div_diff = div_sh - {1'b0, dvs};
    prod     = {hi[XLEN-1:0], lo};
    prod_s   = neg_lo ? -prod : prod;
  end

  assign done = busy && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      dvs    <= '0;
      fun_q  <= ALU_MUL;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else if (kill) begin
      busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      fun_q  <= fun;
      hi     <= '0;
      lo     <= a_mag;
      dvs    <= b_mag;
      // divide by zero keeps the all-ones quotient unsigned
      neg_lo <= (a_neg ^ b_neg) && (b != '0);
      neg_hi <= a_neg;
    end else if (busy && en) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
      if (fun_q[2]) begin
        if (!div_diff[XLEN]) begin
          hi <= div_diff;
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_sh;
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi, lo} <= {1'b0, mul_nxt, lo[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    result = '0;
    case (fun_q)
      ALU_MUL:            result = lo;
      ALU_MULH:           result = prod_s[2*XLEN-1:XLEN];
      ALU_MULHU:          result = hi[XLEN-1:0];
      ALU_DIV, ALU_DIVU:  result = neg_lo ? -lo : lo;
      ALU_REM, ALU_REMU:  result = neg_hi ? -hi[XLEN-1:0] : hi[XLEN-1:0];
      default:            result = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: decode->execute register, N-source bypass, ALU and, when
// EXEC_MULDIV_EN is defined, the iterative MDU with its IDLE/BUSY/DONE FSM.
module exec_stage
  import exec_stage_pkg::*;
#(parameter int XLEN = 32, parameter int NUM_BYPASS = 3) (
  input  logic                            clk,
  input  logic                            rst_n,
  exec_stage_if.slave                     dec,
  input  logic                            pipeline_kill,
  input  logic                            mem_stall,
  input  logic [NUM_BYPASS-1:0]           byp_valid,
  input  logic [NUM_BYPASS-1:0][4:0]      byp_addr,
  input  logic [NUM_BYPASS-1:0][XLEN-1:0] byp_data,
  output logic                            ex_valid,
  output logic [XLEN-1:0]                 ex_pc,
  output logic [31:0]                     ex_inst,
  output logic [4:0]                      ex_wb_addr,
  output logic [XLEN-1:0]                 ex_rs2_data,
  output exec_ctrl_t                      ex_ctrl,
  output logic [XLEN-1:0]                 ex_result,
  output logic                            ex_busy,
  output logic                            ex_illegal
);
  localparam int SHW = $clog2(XLEN);

  logic            adv, cap, valid_q;
  logic [XLEN-1:0] op1_q, op2_q, op1_d, op2_d, rs2_d, fwd1, fwd2, alu_res;
  logic            hit1, hit2;
  logic [SHW-1:0]  shamt;

  assign adv = dec.ready && !mem_stall;
  assign cap = adv && dec.valid && !dec.kill && !pipeline_kill;

  // Scan from the oldest source down so the lowest index wins.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
      if (byp_valid[i] && byp_addr[i] == dec.rs1_addr) begin hit1 = 1'b1; fwd1 = byp_data[i]; end
      if (byp_valid[i] && byp_addr[i] == dec.rs2_addr) begin hit2 = 1'b1; fwd2 = byp_data[i]; end
    end
    op1_d = (hit1 && dec.rs1_addr != 5'd0 && dec.ctrl.op1_sel == OP1_RS1) ? fwd1 : dec.op1_data;
    op2_d = (hit2 && dec.rs2_addr != 5'd0 && dec.ctrl.op2_sel == OP2_RS2) ? fwd2 : dec.op2_data;
    rs2_d = (hit2 && dec.rs2_addr != 5'd0) ? fwd2 : dec.rs2_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ex_pc       <= '0;
      ex_inst     <= '0;
      ex_wb_addr  <= '0;
      ex_rs2_data <= '0;
      ex_ctrl     <= CTRL_BUBBLE;
      op1_q       <= '0;
      op2_q       <= '0;
    end else if (pipeline_kill || adv) begin
      valid_q    <= cap;
      ex_inst    <= cap ? dec.inst : '0;
      ex_wb_addr <= cap ? dec.wb_addr : '0;
      ex_ctrl    <= cap ? dec.ctrl : CTRL_BUBBLE;
      if (!pipeline_kill) begin
        ex_pc       <= dec.pc;
        ex_rs2_data <= rs2_d;
        op1_q       <= op1_d;
        op2_q       <= op2_d;
      end
    end
  end

  assign shamt = op2_q[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ex_ctrl.alu_fun)
      ALU_ADD:   alu_res = op1_q + op2_q;
      ALU_SUB:   alu_res = op1_q - op2_q;
      ALU_SLL:   alu_res = op1_q << shamt;
      ALU_SRL:   alu_res = op1_q >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op1_q) >>> shamt);
      ALU_AND:   alu_res = op1_q & op2_q;
      ALU_OR:    alu_res = op1_q | op2_q;
      ALU_XOR:   alu_res = op1_q ^ op2_q;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op1_q) < $signed(op2_q)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op1_q < op2_q};
      ALU_COPY1: alu_res = op1_q;
      default:   alu_res = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  mdu_state_e      state, state_nxt;
  logic            md_start, md_busy, md_done;
  logic [XLEN-1:0] md_result;

  assign md_start = cap && is_mdu(dec.ctrl.alu_fun);

  exec_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .kill   (pipeline_kill),
    .en     (!mem_stall),
    .fun    (dec.ctrl.alu_fun),
    .a      (op1_d),
    .b      (op2_d),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pipeline_kill) begin
      state_nxt = S_IDLE;
    end else if (!mem_stall) begin
      case (state)
        S_BUSY:  if (md_done) state_nxt = S_DONE;
        default: state_nxt = md_start ? S_BUSY : S_IDLE;
      endcase
    end
  end

  assign dec.ready  = (state != S_BUSY);
  assign ex_busy    = md_busy;
  assign ex_valid   = valid_q && (!is_mdu(ex_ctrl.alu_fun) || state == S_DONE);
  assign ex_result  = (state == S_DONE) ? md_result : alu_res;
  assign ex_illegal = 1'b0;
`else
  assign dec.ready  = 1'b1;
  assign ex_busy    = 1'b0;
  assign ex_valid   = valid_q;
  assign ex_result  = is_mdu(ex_ctrl.alu_fun) ? '0 : alu_res;
  assign ex_illegal = valid_q && is_mdu(ex_ctrl.alu_fun);
`endif

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: ALU table, bypass priority, bubbles, stall/kill,
// and MDU results/latency (or the illegal-op path when the MDU is compiled out).
module tb_exec_stage;
  import exec_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int NB   = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    pipeline_kill, mem_stall;
  logic [NB-1:0]           byp_valid;
  logic [NB-1:0][4:0]      byp_addr;
  logic [NB-1:0][XLEN-1:0] byp_data;
  logic                    ex_valid, ex_busy, ex_illegal;
  logic [XLEN-1:0]         ex_pc, ex_rs2_data, ex_result;
  logic [31:0]             ex_inst;
  logic [4:0]              ex_wb_addr;
  exec_ctrl_t              ex_ctrl;

  exec_stage_if #(.XLEN(XLEN)) dec ();

  exec_stage #(.XLEN(XLEN), .NUM_BYPASS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .dec(dec), .pipeline_kill(pipeline_kill), .mem_stall(mem_stall),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_wb_addr(ex_wb_addr),
    .ex_rs2_data(ex_rs2_data), .ex_ctrl(ex_ctrl), .ex_result(ex_result),
    .ex_busy(ex_busy), .ex_illegal(ex_illegal));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input alu_fun_e f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    dec.valid        = 1'b1;
    dec.kill         = 1'b0;
    dec.ctrl         = CTRL_BUBBLE;
    dec.ctrl.alu_fun = f;
    dec.ctrl.rf_wen  = 1'b1;
    dec.op1_data     = a;
    dec.op2_data     = b;
    dec.rs1_addr     = 5'd0;
    dec.rs2_addr     = 5'd0;
    dec.wb_addr      = 5'd3;
    dec.inst         = 32'h0000_0033;
  endtask

  typedef struct {
    alu_fun_e    f;
    logic [31:0] a, b, e;
  } vec_t;

  vec_t alu_v [11];

`ifdef EXEC_MULDIV_EN
  task automatic mdu(input string tag, input alu_fun_e f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e, input int stall_at);
    int cyc;
    set_op(f, a, b);
    step();
    dec.valid = 1'b0;
    chk({tag, " busy/ready/valid"}, {ex_busy, dec.ready, ex_valid}, 3'b100);
    cyc = 0;
    while (!ex_valid && cyc < 200) begin
      if (cyc == stall_at)     mem_stall = 1'b1;
      if (cyc == stall_at + 3) mem_stall = 1'b0;
      step();
      cyc++;
    end
    mem_stall = 1'b0;
    chk({tag, " latency"}, cyc, (stall_at >= 0) ? XLEN + 3 : XLEN);
    chk({tag, " result"}, ex_result, e);
    step();
  endtask
`endif

  initial begin
    alu_v = '{
      '{ALU_SUB,   32'd5,         32'd7,  32'hFFFF_FFFE},
      '{ALU_SLL,   32'd1,         32'd33, 32'h0000_0002},
      '{ALU_SRL,   32'h8000_0000, 32'd4,  32'h0800_0000},
      '{ALU_SRA,   32'h8000_0000, 32'd4,  32'hF800_0000},
      '{ALU_SRA,   32'h8000_0000, 32'd31, 32'hFFFF_FFFF},
      '{ALU_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000},
      '{ALU_OR,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0},
      '{ALU_XOR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0},
      '{ALU_SLT,   32'hFFFF_FFFF, 32'd5,  32'h0000_0001},
      '{ALU_SLTU,  32'hFFFF_FFFF, 32'd5,  32'h0000_0000},
      '{ALU_COPY1, 32'hDEAD_BEEF, 32'd1,  32'hDEAD_BEEF}};

    rst_n = 1'b0; pipeline_kill = 1'b0; mem_stall = 1'b0;
    byp_valid = '0; byp_addr = '0; byp_data = '0;
    dec.valid = 1'b0; dec.kill = 1'b0; dec.pc = '0; dec.inst = '0; dec.wb_addr = '0;
    dec.rs1_addr = '0; dec.rs2_addr = '0; dec.op1_data = '0; dec.op2_data = '0;
    dec.rs2_data = '0; dec.ctrl = CTRL_BUBBLE;
    #12;
    chk("rst valid", ex_valid, 0);
    chk("rst inst", ex_inst, 0);
    chk("rst rf_wen", ex_ctrl.rf_wen, 0);
    chk("rst busy/ready", {ex_busy, dec.ready}, 2'b01);
    rst_n = 1'b1;

    set_op(ALU_ADD, 32'd5, 32'd7);
    dec.pc = 32'h100;
    step();
    chk("add valid", ex_valid, 1);
    chk("add result", ex_result, 12);
    chk("add rf_wen/wb", {ex_ctrl.rf_wen, ex_wb_addr}, {1'b1, 5'd3});
    chk("add pc", ex_pc, 32'h100);

    foreach (alu_v[i]) begin
      set_op(alu_v[i].f, alu_v[i].a, alu_v[i].b);
      step();
      chk($sformatf("alu %s", alu_v[i].f.name()), ex_result, alu_v[i].e);
    end

    set_op(ALU_COPY1, 32'h55, 32'h0);
    dec.rs1_addr = 5'd4;
    byp_valid = 3'b011; byp_addr[0] = 5'd4; byp_addr[1] = 5'd4;
    byp_data[0] = 32'hA; byp_data[1] = 32'hB;
    step();
    chk("byp op1 prio", ex_result, 32'hA);
    byp_valid = 3'b010;
    step();
    chk("byp op1 src1", ex_result, 32'hB);
    dec.rs1_addr = 5'd0; byp_addr[0] = 5'd0; byp_addr[1] = 5'd0; byp_valid = 3'b011;
    step();
    chk("byp rs1 zero", ex_result, 32'h55);
    dec.rs1_addr = 5'd4; byp_addr[0] = 5'd4; byp_addr[1] = 5'd4;
    dec.ctrl.op1_sel = OP1_PC;
    step();
    chk("byp op1_sel pc", ex_result, 32'h55);

    set_op(ALU_ADD, 32'h0, 32'h100);
    dec.rs2_addr = 5'd5; dec.rs2_data = 32'h77;
    byp_valid = 3'b100; byp_addr[2] = 5'd5; byp_data[2] = 32'h30;
    step();
    chk("byp op2", ex_result, 32'h30);
    chk("byp rs2_data", ex_rs2_data, 32'h30);
    dec.ctrl.op2_sel = OP2_ITYPE;
    step();
    chk("byp op2 itype", ex_result, 32'h100);
    chk("byp rs2 itype", ex_rs2_data, 32'h30);
    byp_valid = '0;

    dec.valid = 1'b0;
    step();
    chk("no valid bubble", {ex_valid, ex_inst}, 33'h0);
    set_op(ALU_ADD, 32'd1, 32'd1);
    dec.kill = 1'b1; dec.pc = 32'h200;
    step();
    chk("dec_kill bubble", {ex_valid, ex_ctrl.rf_wen, ex_inst}, 34'h0);
    chk("dec_kill pc", ex_pc, 32'h200);

    set_op(ALU_ADD, 32'd1, 32'd2);
    dec.pc = 32'h300;
    step();
    mem_stall = 1'b1;
    set_op(ALU_ADD, 32'd10, 32'd10);
    dec.pc = 32'h304;
    repeat (3) step();
    chk("stall hold", {ex_valid, ex_result}, {1'b1, 32'd3});
    chk("stall pc", ex_pc, 32'h300);
    mem_stall = 1'b0;
    step();
    chk("stall release", ex_result, 32'd20);

    mem_stall = 1'b1; pipeline_kill = 1'b1;
    step();
    chk("kill beats stall", {ex_valid, ex_ctrl.rf_wen}, 2'b00);
    mem_stall = 1'b0; pipeline_kill = 1'b0;

`ifdef EXEC_MULDIV_EN
    mdu("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, -1);
    mdu("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, -1);
    mdu("div0", ALU_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, -1);
    mdu("divovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1);
    mdu("removf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, -1);
    mdu("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    mdu("mulh", ALU_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, -1);
    mdu("mul stall", ALU_MUL, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 5);

    begin
      logic late;
      set_op(ALU_DIVU, 32'd100, 32'd7);
      step();
      dec.valid = 1'b0;
      repeat (10) step();
      pipeline_kill = 1'b1;
      step();
      pipeline_kill = 1'b0;
      chk("kill busy", {ex_valid, ex_ctrl.rf_wen, dec.ready, ex_busy}, 4'b0010);
      late = 1'b0;
      repeat (XLEN + 2) begin
        step();
        if (ex_valid) late = 1'b1;
      end
      chk("kill no late result", late, 0);
    end
`else
    set_op(ALU_DIVU, 32'd100, 32'd7);
    step();
    chk("mdu off valid/illegal", {ex_valid, ex_illegal}, 2'b11);
    chk("mdu off result", ex_result, 0);
    chk("mdu off busy/ready", {ex_busy, dec.ready}, 2'b01);
    set_op(ALU_ADD, 32'd2, 32'd2);
    step();
    chk("illegal clears", {ex_illegal, ex_result}, {1'b0, 32'd4});
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
